// File: rtl/acc_stream_loader.sv
// -----------------------------------------------------------------------------
// acc_stream_loader
//
// Streaming front/back end for the 3x3 matrix-multiply accelerator.
// Operand bytes arrive on a valid/ready stream (all of A, then all of B, in
// row-major order). They are held on the parallel mat_A/mat_B buses that drive
// the multiplier. After MUL_LAT cycles the 9 products on mat_C are captured,
// then streamed out one element per valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   clear      synchronous abort back to LOAD_A; mat_A/mat_B are kept
//   in_valid   operand byte valid
//   in_ready   loader accepts an operand byte (LOAD_A / LOAD_B only)
//   in_data    operand byte
//   mat_A      operand A to the multiplier, element i = row i/3, col i%3
//   mat_B      operand B to the multiplier
//   mat_C      product from the multiplier
//   out_valid  result element valid (DRAIN only)
//   out_ready  consumer accepts the result element
//   out_data   result element, held stable while stalled
//   busy       high in every state except LOAD_A with idx == 0
// -----------------------------------------------------------------------------
module acc_stream_loader #(
    parameter int DAT_SIZE = 8,
    parameter int RES_SIZE = 16,
    parameter int N_ELEM   = 9,
    parameter int MUL_LAT  = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DAT_SIZE-1:0]                in_data,
    output logic [N_ELEM-1:0][DAT_SIZE-1:0]    mat_A,
    output logic [N_ELEM-1:0][DAT_SIZE-1:0]    mat_B,
    input  logic [N_ELEM-1:0][RES_SIZE-1:0]    mat_C,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [RES_SIZE-1:0]                out_data,
    output logic                               busy
);

    localparam int IDX_W  = $clog2(N_ELEM);
    localparam int WCNT_W = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_ELEM - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MUL_LAT);

    typedef enum logic [1:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_DRAIN
    } state_e;

    state_e                             state_q,     state_d;
    logic [IDX_W-1:0]                   idx_q,       idx_d;
    logic [WCNT_W-1:0]                  wait_cnt_q,  wait_cnt_d;
    logic [N_ELEM-1:0][DAT_SIZE-1:0]    mat_a_q,     mat_a_d;
    logic [N_ELEM-1:0][DAT_SIZE-1:0]    mat_b_q,     mat_b_d;
    logic [N_ELEM-1:0][RES_SIZE-1:0]    result_q,    result_d;
    logic                               out_valid_q, out_valid_d;
    logic [RES_SIZE-1:0]                out_data_q,  out_data_d;

    logic in_xfer;
    logic out_xfer;

    // in_ready depends on state only, so there is no combinational
    // path from in_valid back to in_ready.
    assign in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    assign in_xfer   = in_ready && in_valid;
    assign out_xfer  = out_valid_q && out_ready;

    assign busy      = !((state_q == S_LOAD_A) && (idx_q == '0));
    assign mat_A     = mat_a_q;
    assign mat_B     = mat_b_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every *_d starts at its current value, so no path through the
        // case below can leave a signal unassigned and infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        wait_cnt_d  = wait_cnt_q;
        mat_a_d     = mat_a_q;
        mat_b_d     = mat_b_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (clear) begin
            // Abort wins over any handshake in the same cycle; the operand
            // buses keep their last contents.
            state_d     = S_LOAD_A;
            idx_d       = '0;
            wait_cnt_d  = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end else begin
            unique case (state_q)
                S_LOAD_A: begin
                    if (in_xfer) begin
                        mat_a_d[idx_q] = in_data;
                        if (idx_q == IDX_LAST) begin
                            state_d = S_LOAD_B;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end

                S_LOAD_B: begin
                    if (in_xfer) begin
                        mat_b_d[idx_q] = in_data;
                        if (idx_q == IDX_LAST) begin
                            state_d    = S_WAIT;
                            idx_d      = '0;
                            wait_cnt_d = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end

                S_WAIT: begin
                    // Capture happens on the edge where the counter already
                    // equals MUL_LAT, i.e. MUL_LAT+1 edges after the last B byte.
                    if (wait_cnt_q == WCNT_LAST) begin
                        result_d    = mat_C;
                        out_data_d  = mat_C[0];
                        out_valid_d = 1'b1;
                        idx_d       = '0;
                        state_d     = S_DRAIN;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                    end
                end

                S_DRAIN: begin
                    if (out_xfer) begin
                        if (idx_q == IDX_LAST) begin
                            state_d     = S_LOAD_A;
                            idx_d       = '0;
                            out_valid_d = 1'b0;
                            out_data_d  = '0;
                        end else begin
                            // Preload the next element so out_data stays a
                            // plain register output.
                            idx_d      = idx_q + IDX_W'(1);
                            out_data_d = result_q[idx_q + IDX_W'(1)];
                        end
                    end
                end

                default: begin
                    state_d = S_LOAD_A;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOAD_A;
            idx_q       <= '0;
            wait_cnt_q  <= '0;
            // NOTE: the operand and result arrays are reset as well, because
            // the multiplier-facing buses must read zero straight out of reset.
            mat_a_q     <= '0;
            mat_b_q     <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_cnt_q  <= wait_cnt_d;
            mat_a_q     <= mat_a_d;
            mat_b_q     <= mat_b_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
